// File: rtl/kv_cmd_master.sv
// Command FIFO and single-outstanding bus master for the key/value store.
// Build option KV_CMD_TIMEOUT_EN adds an ACK watchdog that aborts with rsp_err=1.
`timescale 1ns/1ps

module kv_cmd_master #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_we,
   input  logic       cmd_adr_is_key,
   input  logic       cmd_dat_is_key,
   input  logic [7:0] cmd_adr,
   input  logic [7:0] cmd_dat,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_dat,
   output logic       rsp_err,
   output logic       STB_o,
   output logic       WE_o,
   output logic       ADR_IS_KEY_o,
   output logic       DAT_IS_KEY_o,
   output logic [7:0] ADR_o,
   output logic [7:0] DAT_o,
   input  logic       ACK_i,
   input  logic [7:0] DAT_i,
   input  logic       STALL_i
);

   // state | meaning
   // IDLE  | no transaction; pop head when FIFO non-empty and store not stalled
   // REQ   | STB_o high, bus fields frozen, waiting for ACK_i (or watchdog)
   // RESP  | response held until rsp_ready while ACK_i is low
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("kv_cmd_master: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("kv_cmd_master: TIMEOUT must be >= 1");
   end

   state_t        state_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [18:0]   mem_q [DEPTH];
   logic [18:0]   head;
   logic          push, pop;

   logic       stb_q, we_q, adr_key_q, dat_key_q, rsp_valid_q;
   logic [7:0] adr_q, dat_q, rsp_dat_q;

   assign cmd_ready = (count_q != CW'(DEPTH));
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == S_IDLE) && (count_q != '0) && !STALL_i;
   assign head      = mem_q[rd_ptr_q];

   always_ff @(posedge sys_clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_we, cmd_adr_is_key, cmd_dat_is_key, cmd_adr, cmd_dat};
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef KV_CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q;
   logic          rsp_err_q;
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_key_q   <= 1'b0;
         dat_key_q   <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
`ifdef KV_CMD_TIMEOUT_EN
         tmo_q       <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  stb_q     <= 1'b1;
                  we_q      <= head[18];
                  adr_key_q <= head[17];
                  dat_key_q <= head[16];
                  adr_q     <= head[15:8];
                  dat_q     <= head[7:0];
                  state_q   <= S_REQ;
`ifdef KV_CMD_TIMEOUT_EN
                  tmo_q     <= '0;
`endif
               end
            end
            S_REQ: begin
               // ACK takes priority over a watchdog expiry in the same cycle
               if (ACK_i) begin
                  stb_q       <= 1'b0;
                  rsp_dat_q   <= DAT_i;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
`ifdef KV_CMD_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
               end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                  stb_q       <= 1'b0;
                  rsp_dat_q   <= 8'hFF;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  tmo_q       <= tmo_q + 1'b1;
`endif
               end
            end
            S_RESP: begin
               // ACK must be low before leaving so the next strobe never overlaps it
               if (rsp_ready && !ACK_i) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign STB_o        = stb_q;
   assign WE_o         = we_q;
   assign ADR_IS_KEY_o = adr_key_q;
   assign DAT_IS_KEY_o = dat_key_q;
   assign ADR_o        = adr_q;
   assign DAT_o        = dat_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_dat      = rsp_dat_q;

endmodule

// File: doc/kv_cmd_master.md
# kv_cmd_master

Bus-master front end for the key/value store. It buffers host commands in a small FIFO and issues them one at a time on the store's STB/WE/ADR/DAT strobe interface. It waits for the store's one-cycle ACK and returns the store's read data (or write result) on a valid/ready response port. It sits directly upstream of the key/value store and is its only master.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT, 15, ACK watchdog limit in cycles (used only with KV_CMD_TIMEOUT_EN)

Ports:
- sys_clk  in  1  sole clock, all state on rising edge
- sys_rst_n  in  1  reset; asynchronous, active-low
- cmd_valid  in  1  host command present
- cmd_ready  out  1  FIFO not full
- cmd_we  in  1  1=write, 0=read
- cmd_adr_is_key  in  1  address field is a key
- cmd_dat_is_key  in  1  data field is a key
- cmd_adr  in  8  address/key
- cmd_dat  in  8  write data
- rsp_valid  out  1  response held
- rsp_ready  in  1  host consumes response
- rsp_dat  out  8  store data captured on ACK
- rsp_err  out  1  response is a timeout abort
- STB_o, WE_o, ADR_IS_KEY_o, DAT_IS_KEY_o  out  1 each  to store
- ADR_o, DAT_o  out  8 each  to store
- ACK_i  in  1  store acknowledge (one-cycle pulse)
- DAT_i  in  8  store data, valid in the ACK cycle
- STALL_i  in  1  store busy; no new strobe while high

## Operation
- FIFO: 19-bit entries {we, adr_is_key, dat_is_key, adr, dat}.
  - Push on cmd_valid & cmd_ready.
  - Occupancy counter is clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
  - cmd_ready = (count != DEPTH), driven combinationally.
  - A simultaneous push and pop leaves count unchanged. A push when full is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE, with FIFO non-empty and STALL_i=0:
  - Pop the head entry and load it into ADR_o/DAT_o/WE_o/flag registers.
  - Set STB_o=1 and go to REQ.
- REQ:
  - STB_o and all bus outputs stay constant, because the store decodes ADR_o combinationally while busy.
  - When ACK_i=1: set rsp_dat←DAT_i, rsp_err←0, STB_o←0, rsp_valid←1, and go to RESP.
- RESP:
  - rsp_valid, rsp_dat and rsp_err are held until rsp_ready=1.
  - Then clear rsp_valid and go to IDLE.
  - Leaving RESP also requires ACK_i=0. This guarantees the store has dropped ACK before the next strobe.
- Writes: rsp_dat returns whatever the store drives, which is the assigned slot index for key writes and the echoed address otherwise.
- Reset (asynchronous, mid-operation included):
  - FIFO is emptied, FSM goes to IDLE, all outputs return to reset values.
  - An in-flight transaction is dropped without a response.

## Timing
- Reset values: STB_o=0, WE_o=0, ADR_IS_KEY_o=0, DAT_IS_KEY_o=0, ADR_o=0, DAT_o=0, rsp_valid=0, rsp_dat=0, rsp_err=0, cmd_ready=1.
- Command pushed at edge N → STB_o high after edge N+1 at the earliest, i.e. one cycle FIFO-to-bus.
- ACK_i sampled high at edge M → STB_o low and rsp_valid high after edge M.
- Minimum spacing between consecutive strobes: 2 cycles after the ACK edge, because RESP must see ACK_i=0 and a response handshake.
- Back-pressure: if rsp_ready stays low, no further strobes issue. The FIFO keeps accepting commands until full.
- STALL_i is only checked in IDLE. Once STB_o is raised it stays high until ACK (or timeout).

## Configuration
- KV_CMD_TIMEOUT_EN defined:
  - A counter clears on entry to REQ and increments each REQ cycle without ACK_i.
  - When it reaches TIMEOUT, the transaction aborts: STB_o←0, rsp_dat←8'hFF, rsp_err←1, go to RESP.
  - ADR_o is held as-is. Recovering the downstream store is a system reset matter.
  - ACK_i and the timeout in the same cycle: ACK wins, rsp_err=0.
- KV_CMD_TIMEOUT_EN undefined: no counter is built, rsp_err is tied 0, and REQ waits indefinitely. A read of an absent key then hangs the block.

## Test plan
- Reset then one read (adr=8'h03, adr_is_key=0); the store model ACKs with DAT_i=8'h5A after 1 cycle → STB_o high for exactly 2 cycles, then rsp_valid=1 with rsp_dat=8'h5A, rsp_err=0.
- Key write (we=1, adr_is_key=1, adr=8'h10, dat=8'h77); the store returns 8'h01 → rsp_dat=8'h01; WE_o=1 and ADR_o/DAT_o stay stable throughout STB_o.
- Push 5 commands back-to-back with DEPTH=4 and the store stalled (STALL_i=1) → cmd_ready drops after the 4th push and the 5th is held. Release STALL_i → all 5 responses come back in order.
- Hold rsp_ready=0 for 10 cycles after a response → rsp_valid and rsp_dat stay stable and no new STB_o is raised. Raise rsp_ready → next strobe 1 cycle later.
- With KV_CMD_TIMEOUT_EN and TIMEOUT=15: read with the ACK never returned → STB_o falls after 15 REQ cycles, response is rsp_dat=8'hFF, rsp_err=1.
- Assert sys_rst_n=0 asynchronously while in REQ with 2 entries queued → STB_o=0 immediately. After release: cmd_ready=1, rsp_valid=0, no strobe issued.
